// File: rtl/sensor_scan_pkg.sv
// Shared types and constants for the sensor scan controller: FSM encoding, channel ids, default thresholds.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sensor_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_EVAL
    } state_t;

    localparam logic CH_AMB  = 1'b0;
    localparam logic CH_BODY = 1'b1;

    localparam logic [7:0] DEF_THR_25   = 8'd100;
    localparam logic [7:0] DEF_THR_27   = 8'd108;
    localparam logic [7:0] DEF_THR_30   = 8'd120;
    localparam logic [7:0] DEF_THR_CORP = 8'd148;

    localparam int DEF_SETTLE_CYC  = 16;
    localparam int DEF_DEB_N       = 3;
    localparam int DEF_TIMEOUT_CYC = 255;

    // The shared ADC alternates between the two channels after every attempt.
    function automatic logic next_ch(input logic ch);
        return ~ch;
    endfunction

endpackage

// File: rtl/sensor_scan_ctrl_flag_debounce.sv
// Debounces one threshold flag: output follows raw only after DEB_N consecutive disagreeing samples.
// Latency: flag updates on the clock edge ending the DEB_N-th disagreeing sample strobe.
// Backpressure: none; raw is only looked at when sample is high.
module flag_debounce #(
    parameter int DEB_N = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic sample,
    output logic flag
);

    localparam int CW = (DEB_N < 2) ? 1 : $clog2(DEB_N);

    logic [CW-1:0] cnt;

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else if (sample) begin
            if (raw == flag) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_N - 1)) begin
                flag <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Time-multiplexes one ADC between ambient and body channels and produces debounced temperature flags.
// Latency: adc_done to flag update is 2 cycles at DEB_N=1; SENSOR_SCAN_TIMEOUT_EN adds a WAIT timeout.
// Backpressure: none; the ADC handshake is start pulse / done strobe, scan_en is only sampled between conversions.
module sensor_scan_ctrl
    import sensor_scan_pkg::*;
#(
    parameter logic [7:0] THR_25      = DEF_THR_25,
    parameter logic [7:0] THR_27      = DEF_THR_27,
    parameter logic [7:0] THR_30      = DEF_THR_30,
    parameter logic [7:0] THR_CORP    = DEF_THR_CORP,
    parameter int         SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int         DEB_N       = DEF_DEB_N,
    parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_en,
    input  logic       err_clr,
    output logic       adc_ch,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic       t_25,
    output logic       t_27,
    output logic       t_30,
    output logic       t_corp,
    output logic       sample_valid,
    output logic       err_timeout
);

    localparam int SCW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

    state_t         state;
    logic [SCW-1:0] settle_cnt;
    logic [7:0]     data_q;
    logic           eval_amb;
    logic           eval_body;

`ifdef SENSOR_SCAN_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    logic [TCW-1:0] wait_cnt;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_timeout    = 1'b0;
`endif

    // Scan sequencer: settle mux, pulse start, wait for result, evaluate, swap channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            adc_ch       <= CH_AMB;
            adc_start    <= 1'b0;
            sample_valid <= 1'b0;
            settle_cnt   <= '0;
            data_q       <= '0;
`ifdef SENSOR_SCAN_TIMEOUT_EN
            wait_cnt     <= '0;
            err_timeout  <= 1'b0;
`endif
        end else begin
            adc_start    <= 1'b0;
            sample_valid <= 1'b0;
`ifdef SENSOR_SCAN_TIMEOUT_EN
            // A timeout set further down in this block overrides a same-cycle clear.
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (scan_en) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                        state     <= ST_START;
                        adc_start <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
`ifdef SENSOR_SCAN_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    // adc_done takes priority over an expiring timeout.
                    if (adc_done) begin
                        data_q       <= adc_data;
                        state        <= ST_EVAL;
                        sample_valid <= 1'b1;
                    end
`ifdef SENSOR_SCAN_TIMEOUT_EN
                    else if (wait_cnt == TCW'(TIMEOUT_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        adc_ch      <= next_ch(adc_ch);
                        state       <= scan_en ? ST_SETTLE : ST_IDLE;
                        settle_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_EVAL: begin
                    adc_ch     <= next_ch(adc_ch);
                    state      <= scan_en ? ST_SETTLE : ST_IDLE;
                    settle_cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // adc_ch still names the converted channel during EVAL; it swaps on the edge leaving EVAL.
    assign eval_amb  = (state == ST_EVAL) && (adc_ch == CH_AMB);
    assign eval_body = (state == ST_EVAL) && (adc_ch == CH_BODY);

    flag_debounce #(.DEB_N(DEB_N)) u_deb_25 (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (data_q >= THR_25),
        .sample  (eval_amb),
        .flag    (t_25)
    );

    flag_debounce #(.DEB_N(DEB_N)) u_deb_27 (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (data_q >= THR_27),
        .sample  (eval_amb),
        .flag    (t_27)
    );

    flag_debounce #(.DEB_N(DEB_N)) u_deb_30 (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (data_q >= THR_30),
        .sample  (eval_amb),
        .flag    (t_30)
    );

    flag_debounce #(.DEB_N(DEB_N)) u_deb_corp (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (data_q >= THR_CORP),
        .sample  (eval_body),
        .flag    (t_corp)
    );

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl with a behavioural ADC and a flag scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sensor_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scan_en;
    logic       err_clr;
    logic       adc_ch;
    logic       adc_start;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       t_25;
    logic       t_27;
    logic       t_30;
    logic       t_corp;
    logic       sample_valid;
    logic       err_timeout;

    always #5 clk = ~clk;

    sensor_scan_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scan_en      (scan_en),
        .err_clr      (err_clr),
        .adc_ch       (adc_ch),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .t_25         (t_25),
        .t_27         (t_27),
        .t_30         (t_30),
        .t_corp       (t_corp),
        .sample_valid (sample_valid),
        .err_timeout  (err_timeout)
    );

    localparam int DEB = 3;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb_q[$];
    logic       mf[4];
    int         mc[4];
    logic       model_ch;
    logic       model_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dflags();
        return {t_25, t_27, t_30, t_corp};
    endfunction

    function automatic logic [3:0] mflags();
        return {mf[0], mf[1], mf[2], mf[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mf[i] = 1'b0;
            mc[i] = 0;
        end
        model_ch  = 1'b0;
        model_err = 1'b0;
        sb_q.delete();
    endtask

    // Reference debounce: thresholds 100/108/120 ambient, 148 body.
    task automatic model_eval(input logic ch, input logic [7:0] d);
        logic raw[4];
        int   lo;
        int   hi;
        raw[0] = (d >= 8'd100);
        raw[1] = (d >= 8'd108);
        raw[2] = (d >= 8'd120);
        raw[3] = (d >= 8'd148);
        lo = ch ? 3 : 0;
        hi = ch ? 3 : 2;
        for (int i = lo; i <= hi; i++) begin
            if (raw[i] == mf[i]) begin
                mc[i] = 0;
            end else begin
                mc[i]++;
                if (mc[i] == DEB) begin
                    mf[i] = raw[i];
                    mc[i] = 0;
                end
            end
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (adc_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("adc_start_seen", 32'(adc_start), 32'd1);
    endtask

    // One conversion; adc_done is raised in WAIT cycle number lat (lat >= 1).
    task automatic do_conv(input logic [7:0] d, input int lat);
        logic [3:0] exp_f;
        wait_start();
        chk("adc_ch", 32'(adc_ch), 32'(model_ch));
        @(negedge clk);
        chk("start_width", 32'(adc_start), 32'd0);
        repeat (lat - 1) @(negedge clk);
        adc_data = d;
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
        adc_data = 8'h00;
        chk("sample_valid", 32'(sample_valid), 32'd1);
        chk("flags_hold_eval", 32'(dflags()), 32'(mflags()));
        model_eval(model_ch, d);
        sb_q.push_back(mflags());
        @(negedge clk);
        chk("sample_valid_drop", 32'(sample_valid), 32'd0);
        exp_f = sb_q.pop_front();
        chk("flags", 32'(dflags()), 32'(exp_f));
        chk("err_timeout", 32'(err_timeout), 32'(model_err));
        model_ch = ~model_ch;
        chk("ch_toggle", 32'(adc_ch), 32'(model_ch));
    endtask

`ifdef SENSOR_SCAN_TIMEOUT_EN
    // Conversion that never completes; optional err_clr on the expiring cycle.
    task automatic do_timeout(input logic clr_at_end);
        logic [3:0] exp_f;
        wait_start();
        chk("to_adc_ch", 32'(adc_ch), 32'(model_ch));
        @(negedge clk);
        repeat (254) @(negedge clk);
        chk("to_no_err_yet", 32'(err_timeout), 32'(model_err));
        err_clr = clr_at_end;
        @(negedge clk);
        err_clr   = 1'b0;
        model_err = 1'b1;
        sb_q.push_back(mflags());
        chk("to_err_set", 32'(err_timeout), 32'd1);
        chk("to_no_sample", 32'(sample_valid), 32'd0);
        exp_f = sb_q.pop_front();
        chk("to_flags_hold", 32'(dflags()), 32'(exp_f));
        model_ch = ~model_ch;
        chk("to_ch_toggle", 32'(adc_ch), 32'(model_ch));
    endtask
`endif

    initial begin
        logic [7:0] seq1[12];
        logic [7:0] seq2[5];
        int         starts;
        int         valids;

        seq1 = '{8'd105, 8'd150, 8'd105, 8'd150, 8'd105, 8'd90,
                 8'd105, 8'd150, 8'd105, 8'd150, 8'd105, 8'd150};
        seq2 = '{8'd120, 8'd150, 8'd120, 8'd150, 8'd120};

        reset_n  = 1'b0;
        scan_en  = 1'b0;
        err_clr  = 1'b0;
        adc_done = 1'b0;
        adc_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_adc_ch", 32'(adc_ch), 32'd0);
        chk("rst_adc_start", 32'(adc_start), 32'd0);
        chk("rst_flags", 32'(dflags()), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", 32'(adc_start), 32'd0);

        // Start pulse lands in the 17th cycle after leaving IDLE.
        scan_en = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            chk("settle_no_start", 32'(adc_start), 32'd0);
            chk("settle_ch", 32'(adc_ch), 32'd0);
            @(negedge clk);
        end
        chk("start_at_17", 32'(adc_start), 32'd1);

        // Ambient 105 repeatedly, body 150,150,90,150,150,150.
        for (int i = 0; i < 12; i++) begin
            if (i == 11) chk("corp_low_before_6th", 32'(t_corp), 32'd0);
            if (i == 4)  chk("t25_low_before_3rd", 32'(t_25), 32'd0);
            do_conv(seq1[i], 1 + (i % 4));
        end
        chk("t25_set", 32'(t_25), 32'd1);
        chk("t27_clear", 32'(t_27), 32'd0);
        chk("t30_clear", 32'(t_30), 32'd0);
        chk("corp_set", 32'(t_corp), 32'd1);

        for (int i = 0; i < 5; i++) begin
            do_conv(seq2[i], 2);
        end
        chk("t30_set", 32'(t_30), 32'd1);

        // Reset in the middle of WAIT.
        wait_start();
        @(negedge clk);
        reset_n = 1'b0;
        scan_en = 1'b0;
        #1;
        chk("mid_rst_ch", 32'(adc_ch), 32'd0);
        chk("mid_rst_flags", 32'(dflags()), 32'd0);
        chk("mid_rst_start", 32'(adc_start), 32'd0);
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_err", 32'(err_timeout), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        adc_data = 8'd200;
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
        adc_data = 8'h00;
        starts = 0;
        valids = 0;
        for (int i = 0; i < 30; i++) begin
            if (adc_start === 1'b1) starts++;
            if (sample_valid === 1'b1) valids++;
            @(negedge clk);
        end
        chk("post_rst_idle_starts", 32'(starts), 32'd0);
        chk("post_rst_late_done", 32'(valids), 32'd0);
        chk("post_rst_flags", 32'(dflags()), 32'd0);

        // scan_en dropped after leaving IDLE: conversion still completes, then idles.
        scan_en = 1'b1;
        @(negedge clk);
        scan_en = 1'b0;
        do_conv(8'd130, 2);
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            if (adc_start === 1'b1) starts++;
            @(negedge clk);
        end
        chk("stop_after_conv", 32'(starts), 32'd0);

        scan_en = 1'b1;
`ifdef SENSOR_SCAN_TIMEOUT_EN
        do_timeout(1'b0);
        do_timeout(1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        model_err = 1'b0;
        chk("err_cleared", 32'(err_timeout), 32'd0);
        do_conv(8'd0, 2);
        do_conv(8'd120, 255);
        do_conv(8'd0, 2);
        do_conv(8'd120, 255);
        do_conv(8'd0, 2);
        do_conv(8'd120, 255);
        chk("edge_t25", 32'(t_25), 32'd1);
        chk("edge_t27", 32'(t_27), 32'd1);
        chk("edge_t30", 32'(t_30), 32'd1);
        chk("edge_no_err", 32'(err_timeout), 32'd0);
`else
        do_conv(8'd0, 300);
        chk("no_timeout_err", 32'(err_timeout), 32'd0);
`endif
        scan_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_scan_ctrl.md
SENSOR_SCAN_CTRL -- requirements
Module: sensor_scan_ctrl

Interface
REQ-001 Parameter THR_25, 8'd100: ambient code threshold for t_25.
REQ-002 Parameter THR_27, 8'd108: ambient code threshold for t_27.
REQ-003 Parameter THR_30, 8'd120: ambient code threshold for t_30.
REQ-004 Parameter THR_CORP, 8'd148: body-channel code threshold for t_corp.
REQ-005 Parameters SETTLE_CYC 16 (mux settle cycles), DEB_N 3 (debounce depth), TIMEOUT_CYC 255 (ADC wait limit).
REQ-006 Ports: clk in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-007 Ports: scan_en in 1, run scanning; err_clr in 1, clears err_timeout.
REQ-008 Ports: adc_ch out 1 (0 ambient, 1 body); adc_start out 1, one-cycle conversion request; adc_done in 1, conversion complete strobe; adc_data in 8, result valid with adc_done.
REQ-009 Ports: t_25, t_27, t_30, t_corp out 1 each, debounced flags to the temperature state machine; sample_valid out 1; err_timeout out 1.

Function
REQ-010 FSM states IDLE, SETTLE, START, WAIT, EVAL; shared ADC time-multiplexed between ambient and body channels.
REQ-011 IDLE: scan_en=1 -> SETTLE next cycle; otherwise stay.
REQ-012 SETTLE: adc_ch stable; exactly SETTLE_CYC cycles, then START.
REQ-013 START: adc_start=1 for exactly one cycle, then WAIT; adc_start=0 in every other state.
REQ-014 WAIT: adc_data captured on the cycle adc_done=1, then EVAL; adc_done outside WAIT ignored.
REQ-015 EVAL (one cycle): sample_valid=1; raw ambient flags = adc_data >= THR_25/THR_27/THR_30 (unsigned, cumulative); raw body flag = adc_data >= THR_CORP.
REQ-016 Each output flag changes only after DEB_N consecutive EVALs of its channel with raw value differing from the current output; any agreeing sample resets that flag's counter.
REQ-017 After EVAL adc_ch toggles; scan_en=1 -> SETTLE, else IDLE; scan_en deassert mid-cycle completes the current conversion first.
REQ-018 adc_done and timeout expiring in the same WAIT cycle: adc_done wins, no error.
REQ-019 err_clr and a new timeout in the same cycle: err_timeout stays 1.
REQ-020 Flags hold their value while idle or on timeout; latency from adc_done to flag update is 2 cycles at DEB_N=1.

Reset
REQ-021 reset_n=0 asynchronously forces IDLE, adc_ch=0, adc_start=0, all t_* =0, sample_valid=0, err_timeout=0, all counters 0.
REQ-022 Reset mid-conversion abandons the sample; a late adc_done after reset release is ignored unless in WAIT.

Configuration
REQ-023 Macro SENSOR_SCAN_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYC without adc_done -> err_timeout=1 (sticky until err_clr), no EVAL, channel toggles, flags unchanged.
REQ-024 Macro undefined: no timeout counter, WAIT indefinite, err_timeout tied 0.

Structure
REQ-025 Package sensor_scan_pkg holds FSM state encoding, channel constants (CH_AMB, CH_BODY), default threshold constants.
REQ-026 One sub-module flag_debounce (DEB_N parameter, raw in, sample strobe in, flag out), instantiated four times.

Verification
REQ-027 scan_en=1, ADC model returns 8'd105 ambient each time, DEB_N=3 -> t_25=1 after 3rd ambient EVAL, t_27=t_30=0.
REQ-028 Body samples 150,150,90,150,150,150 -> t_corp rises only on 6th body EVAL.
REQ-029 Timing: adc_start pulse exactly SETTLE_CYC+1 cycles after leaving IDLE, width 1 cycle, adc_ch alternates 0,1,0.
REQ-030 SENSOR_SCAN_TIMEOUT_EN, adc_done never asserted -> err_timeout=1 after 255 WAIT cycles, adc_ch toggles; err_clr pulse -> 0.
REQ-031 Assert reset_n=0 during WAIT with t_30=1 -> all outputs 0 immediately, IDLE on release.
REQ-032 Ambient 8'd120 with adc_done at timeout cycle -> no error, all three ambient flags set after debounce.
